// File: rtl/cla_16bit_pipelined.sv
`default_nettype none
// ============================================================================
// cla_16bit_pipelined : two-stage 16-bit carry look-ahead adder, valid/ready
// Revision 1.0
// ============================================================================
module cla_16bit_pipelined (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        c_out,
  output logic        p,
  output logic        g,
  output logic        overflow
);

  // Bit-level and slice-level propagate/generate from the raw operands.
  logic [15:0] bit_p, bit_g;
  logic [3:0]  slc_p, slc_g;

  assign bit_p = in1 ^ in2;
  assign bit_g = in1 & in2;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_slice_pg
      localparam int B = 4 * k;
      assign slc_p[k] = &bit_p[B +: 4];
      assign slc_g[k] = bit_g[B+3]
                      | (bit_p[B+3] & bit_g[B+2])
                      | (bit_p[B+3] & bit_p[B+2] & bit_g[B+1])
                      | (bit_p[B+3] & bit_p[B+2] & bit_p[B+1] & bit_g[B]);
    end
  endgenerate

  logic        s1_valid;
  logic [15:0] s1_pi, s1_gi;
  logic [3:0]  s1_p, s1_g;
  logic        s1_cin;

  logic s2_adv, s1_adv;
  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  // Second-level look-ahead: each slice carry-in directly from registered P/G.
  logic [4:0] slc_c;
  assign slc_c[0] = s1_cin;
  assign slc_c[1] = s1_g[0] | (s1_p[0] & s1_cin);
  assign slc_c[2] = s1_g[1] | (s1_p[1] & s1_g[0]) | (s1_p[1] & s1_p[0] & s1_cin);
  assign slc_c[3] = s1_g[2] | (s1_p[2] & s1_g[1]) | (s1_p[2] & s1_p[1] & s1_g[0])
                  | (s1_p[2] & s1_p[1] & s1_p[0] & s1_cin);
  assign slc_c[4] = s1_g[3] | (s1_p[3] & s1_g[2]) | (s1_p[3] & s1_p[2] & s1_g[1])
                  | (s1_p[3] & s1_p[2] & s1_p[1] & s1_g[0])
                  | (s1_p[3] & s1_p[2] & s1_p[1] & s1_p[0] & s1_cin);

  logic [15:0] bit_c;
  generate
    for (genvar k = 0; k < 4; k++) begin : g_slice_carry
      localparam int B = 4 * k;
      assign bit_c[B]   = slc_c[k];
      assign bit_c[B+1] = s1_gi[B] | (s1_pi[B] & slc_c[k]);
      assign bit_c[B+2] = s1_gi[B+1] | (s1_pi[B+1] & s1_gi[B])
                        | (s1_pi[B+1] & s1_pi[B] & slc_c[k]);
      assign bit_c[B+3] = s1_gi[B+2] | (s1_pi[B+2] & s1_gi[B+1])
                        | (s1_pi[B+2] & s1_pi[B+1] & s1_gi[B])
                        | (s1_pi[B+2] & s1_pi[B+1] & s1_pi[B] & slc_c[k]);
    end
  endgenerate

  logic [15:0] sum_d;
  logic        grp_p, grp_g, ovf_d;
  assign sum_d = s1_pi ^ bit_c;
  assign grp_p = &s1_p;
  assign grp_g = s1_g[3] | (s1_p[3] & s1_g[2]) | (s1_p[3] & s1_p[2] & s1_g[1])
               | (s1_p[3] & s1_p[2] & s1_p[1] & s1_g[0]);
  assign ovf_d = slc_c[4] ^ bit_c[15];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_pi     <= '0;
      s1_gi     <= '0;
      s1_p      <= '0;
      s1_g      <= '0;
      s1_cin    <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      p         <= 1'b0;
      g         <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_pi  <= bit_p;
          s1_gi  <= bit_g;
          s1_p   <= slc_p;
          s1_g   <= slc_g;
          s1_cin <= c_in;
        end
      end
      // Result registers only load on a real transaction so bubbles keep old data.
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          sum      <= sum_d;
          c_out    <= slc_c[4];
          p        <= grp_p;
          g        <= grp_g;
          overflow <= ovf_d;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_16bit_pipelined.sv
`default_nettype none
// Directed-vector bench for cla_16bit_pipelined.
module tb_cla_16bit_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1, in2;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out, p, g, overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla_16bit_pipelined dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .p(p), .g(g), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view {out_valid, c_out, p, g, overflow, sum}
  function automatic logic [31:0] pack(input logic v, input logic co, input logic pp,
                                       input logic gg, input logic ov, input logic [15:0] s);
    return {11'd0, v, co, pp, gg, ov, s};
  endfunction

  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [15:0] es, input logic eco,
                       input logic ep, input logic eg, input logic eov);
    in_valid = 1'b1; in1 = a; in2 = b; c_in = ci; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check(tag, pack(out_valid, c_out, p, g, overflow, sum), pack(1'b1, eco, ep, eg, eov, es));
    tick();
  endtask

  logic [15:0] va [8];
  logic [15:0] vb [8];
  logic        vc [8];
  logic [16:0] ref_sum;
  logic        ref_ov;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; c_in = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_out", pack(out_valid, c_out, p, g, overflow, sum), 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    apply("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    apply("add_ffff_cin",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    apply("add_7fff_1",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
    apply("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Backpressure: two held, third refused until the output drains
    @(negedge clk);
    check("bp_idle", {31'd0, out_valid}, 32'd0);
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in1 = 16'd1; in2 = 16'd1; c_in = 1'b0;
    @(negedge clk); check("bp_rdy0", {31'd0, in_ready}, 32'd1);
    tick();
    in1 = 16'd2; in2 = 16'd2;
    @(negedge clk); check("bp_rdy1", {31'd0, in_ready}, 32'd1);
    tick();
    in1 = 16'd3; in2 = 16'd3;
    @(negedge clk);
    check("bp_full", {31'd0, in_ready}, 32'd0);
    check("bp_hold0", {15'd0, out_valid, sum}, {15'd0, 1'b1, 16'h0002});
    tick();
    @(negedge clk);
    check("bp_hold1", {14'd0, in_ready, out_valid, sum}, {14'd0, 1'b0, 1'b1, 16'h0002});
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_rdy", {31'd0, in_ready}, 32'd1);
    check("bp_out0", {15'd0, out_valid, sum}, {15'd0, 1'b1, 16'h0002});
    tick();
    in_valid = 1'b0;
    @(negedge clk); check("bp_out1", {15'd0, out_valid, sum}, {15'd0, 1'b1, 16'h0004});
    tick();
    @(negedge clk); check("bp_out2", {15'd0, out_valid, sum}, {15'd0, 1'b1, 16'h0006});
    tick();
    @(negedge clk); check("bp_empty", {15'd0, out_valid, sum}, {15'd0, 1'b0, 16'h0006});
    tick();

    // Streaming: eight back-to-back operand sets
    va[0] = 16'hA5A5; vb[0] = 16'h5A5A; vc[0] = 1'b1;
    va[1] = 16'h0F0F; vb[1] = 16'hF0F1; vc[1] = 1'b0;
    va[2] = 16'h4000; vb[2] = 16'h4000; vc[2] = 1'b0;
    va[3] = 16'hC000; vb[3] = 16'hBFFF; vc[3] = 1'b1;
    va[4] = 16'h1357; vb[4] = 16'h2468; vc[4] = 1'b1;
    va[5] = 16'hFFFF; vb[5] = 16'hFFFF; vc[5] = 1'b1;
    va[6] = 16'h8001; vb[6] = 16'h7FFE; vc[6] = 1'b0;
    va[7] = 16'h0000; vb[7] = 16'h0000; vc[7] = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1; in1 = va[cyc]; in2 = vb[cyc]; c_in = vc[cyc];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc >= 2 && cyc < 10) begin
        ref_sum = {1'b0, va[cyc-2]} + {1'b0, vb[cyc-2]} + {16'd0, vc[cyc-2]};
        ref_ov  = (va[cyc-2][15] == vb[cyc-2][15]) && (ref_sum[15] != va[cyc-2][15]);
        check($sformatf("stream%0d", cyc - 2),
              {13'd0, out_valid, overflow, c_out, sum},
              {13'd0, 1'b1, ref_ov, ref_sum[16], ref_sum[15:0]});
      end else begin
        check($sformatf("stream_idle%0d", cyc), {31'd0, out_valid}, 32'd0);
      end
      tick();
    end

    // Reset with two transactions in flight
    out_ready = 1'b0; in_valid = 1'b1; in1 = 16'h1111; in2 = 16'h2222; c_in = 1'b0;
    tick();
    in1 = 16'h3333; in2 = 16'h4444;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("pre_rst_valid", {15'd0, out_valid, sum}, {15'd0, 1'b1, 16'h3333});
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_outs", pack(out_valid, c_out, p, g, overflow, sum), 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("rst_no_stale%0d", k), {31'd0, out_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_16bit_pipelined.md
Name:
cla_16bit_pipelined

Overview:
- Two-stage pipelined 16-bit carry look-ahead adder built from four 4-bit augmented CLA slices.
- Sits directly downstream of the 4-bit augmented CLA slice and consumes each slice's group propagate/generate (p, g).
- Stage 1 registers the per-slice p/g and bit-level propagate/generate.
- Stage 2 is the second-level look-ahead carry unit and the final sum, with valid/ready handshake on both sides.

Parameters:
- None. Width is fixed at 16 bits, as four 4-bit slices.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in1/in2/c_in hold a valid operand set.
- in_ready  output  1  block accepts operands this cycle.
- in1  input  16  operand A.
- in2  input  16  operand B.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  result outputs valid.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  16  in1 + in2 + c_in, modulo 2^16.
- c_out  output  1  carry out of bit 15 (c16).
- p  output  1  16-bit group propagate: AND of all bit propagates.
- g  output  1  16-bit group generate.
- overflow  output  1  two's-complement overflow, c16 XOR c15.

Behaviour:
- Bit signals: pi = in1[i]^in2[i], gi = in1[i]&in2[i].
- Slice k covers bits 4k..4k+3. Pk = AND of its four pi. Gk = g3 | p3g2 | p3p2g1 | p3p2p1g0, using the slice's local bits.
- Stage 1 (s1) registers on acceptance: pi[15:0], gi[15:0], P[3:0], G[3:0], c_in, and s1_valid.
- Stage 2 computes slice carries from the registered values:
  - c4 = G0 | P0c0
  - c8 = G1 | P1G0 | P1P0c0
  - c12 and c16 follow the same expansion.
  - There is no ripple between slices.
  - In-slice carries come from the slice's own look-ahead: cj+1 = gj | pj·cj, expanded.
  - sum[i] = pi ^ ci.
  - Group outputs: p = P3P2P1P0; g = G3 | P3G2 | P3P2G1 | P3P2P1G0. g is independent of c_in; c_out = g | p·c_in.
- Output register holds sum, c_out, p, g, overflow and out_valid.
- Handshake:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational).
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - On s2_adv: out_valid <= s1_valid, and result registers load when s1_valid = 1.
  - On s1_adv: s1_valid <= in_valid, and s1 data loads when in_valid = 1.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput: 1 result per cycle.
- Backpressure: with out_ready low, at most 2 transactions are held (s1 and the output register). in_ready drops in the cycle both are full.
- Stability: outputs stay stable while out_valid & !out_ready.
- Simultaneous events: transfers in and out in the same cycle are both legal, and the pipeline shifts without a bubble.
- Ordering: results leave strictly in acceptance order; no drop, no duplication.
- Reset (synchronous, active-high):
  - s1_valid = 0, out_valid = 0.
  - sum, c_out, p, g, overflow = 0; all s1 data registers = 0.
  - in_ready reads 1 in the first cycle after reset deasserts.
  - Reset mid-operation discards in-flight transactions, and no stale out_valid follows.
- in_valid = 0 bubbles propagate as invalid stages; result registers keep their previous values.

Test Plan:
- 0x1234 + 0x4321, c_in=0, out_ready=1 -> after 2 cycles sum=0x5555, c_out=0, p=0, g=0, overflow=0.
- 0xFFFF + 0x0000, c_in=1 -> sum=0x0000, c_out=1, p=1, g=0, overflow=0. This checks carry through all four slices via P only.
- 0x7FFF + 0x0001, c_in=0 -> sum=0x8000, c_out=0, overflow=1. Then 0x8000 + 0x8000, c_in=0 -> sum=0x0000, c_out=1, g=1, overflow=1.
- Backpressure: hold out_ready=0 and offer 3 back-to-back operand sets (1+1, 2+2, 3+3):
  - Two are accepted and in_ready falls.
  - Raising out_ready yields 0x0002, 0x0004, 0x0006 in order, one per cycle.
  - Outputs are stable while stalled.
- Streaming: 8 consecutive random operand sets with out_ready=1 -> 8 results on 8 consecutive cycles starting 2 cycles after the first, each matching a reference add.
- Reset mid-operation: assert rst for one cycle with 2 transactions in flight -> out_valid=0 and all outputs 0 the next cycle, with no in-flight result emitted afterwards. in_ready=1 after rst drops.
